l2cache_axi_bridge: RTL

//   Memory-side responder for the L2 cache mem port. Accepts one cached line read/write or one

---
 rtl/l2cache_axi_bridge.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/l2cache_axi_bridge.sv
// L2 cache memory-port responder: runs one cached line or one uncached word access at a time
// as an AXI4 INCR master transaction with 32-bit data, then returns the result to L2.
module l2cache_axi_bridge #(
  parameter int offset_width = 3
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [31:0]                         addr_l2cache_mem_r,
  input  logic [31:0]                         addr_l2cache_mem_w,
  input  logic [32*(1<<offset_width)-1:0]     dout_l2cache_mem,
  output logic [32*(1<<offset_width)-1:0]     din_mem_l2cache,
  input  logic                                l2cache_mem_req_r,
  input  logic                                l2cache_mem_req_w,
  input  logic                                l2cache_mem_SUC,
  input  logic [3:0]                          l2cache_mem_wstrb,
  input  logic [1:0]                          l2cache_mem_size,
  input  logic                                l2cache_mem_rdy,
  output logic                                mem_l2cache_addrOK_r,
  output logic                                mem_l2cache_addrOK_w,
  output logic                                mem_l2cache_dataOK,
  output logic [31:0]                         araddr,
  output logic [7:0]                          arlen,
  output logic [2:0]                          arsize,
  output logic [1:0]                          arburst,
  output logic                                arvalid,
  input  logic                                arready,
  input  logic [31:0]                         rdata,
  input  logic                                rlast,
  input  logic                                rvalid,
  output logic                                rready,
  output logic [31:0]                         awaddr,
  output logic [7:0]                          awlen,
  output logic [2:0]                          awsize,
  output logic [1:0]                          awburst,
  output logic                                awvalid,
  input  logic                                awready,
  output logic [31:0]                         wdata,
  output logic [3:0]                          wstrb,
  output logic                                wlast,
  output logic                                wvalid,
  input  logic                                wready,
  input  logic                                bvalid,
  output logic                                bready
);

  localparam int BEATS = 1 << offset_width;
  localparam int LINE  = 32 * BEATS;
  localparam logic [7:0] LINE_LEN = 8'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_AR = 3'd1,
    RD_R  = 3'd2,
    WR_AW = 3'd3,
    WR_W  = 3'd4,
    WR_B  = 3'd5,
    RESP  = 3'd6
  } state_e;

  state_e                    state_q;
  logic [offset_width-1:0]   cnt_q;
  logic [offset_width-1:0]   cnt_d;
  logic [LINE-1:0]           buf_q;
  logic [3:0]                beat_strb_q;
  logic [31:0]               araddr_q;
  logic [7:0]                arlen_q;
  logic [2:0]                arsize_q;
  logic [1:0]                arburst_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic [31:0]               awaddr_q;
  logic [7:0]                awlen_q;
  logic [2:0]                awsize_q;
  logic [1:0]                awburst_q;
  logic                      awvalid_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic                      wlast_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      dataok_q;
  logic                      idle_s;
  logic                      addr_ok_w_s;
  logic                      addr_ok_r_s;
  logic [31:0]               next_word_s;
  logic                      next_last_s;

  // Request acceptance and next-beat selection
  always_comb begin
    idle_s      = (state_q == IDLE);
    // Write wins so a dirty writeback always leaves before the refill that replaces it.
    addr_ok_w_s = rstn & idle_s & l2cache_mem_req_w;
    addr_ok_r_s = rstn & idle_s & l2cache_mem_req_r & ~l2cache_mem_req_w;
    cnt_d       = cnt_q + {{(offset_width-1){1'b0}}, 1'b1};
    next_word_s = buf_q[{cnt_d, 5'd0} +: 32];
    next_last_s = (cnt_d == awlen_q[offset_width-1:0]);
  end

  // Transaction FSM with registered AXI and L2-side outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= {offset_width{1'b0}};
      buf_q       <= {LINE{1'b0}};
      beat_strb_q <= 4'h0;
      araddr_q    <= 32'h0;
      arlen_q     <= 8'h0;
      arsize_q    <= 3'd0;
      arburst_q   <= 2'b00;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= 32'h0;
      awlen_q     <= 8'h0;
      awsize_q    <= 3'd0;
      awburst_q   <= 2'b00;
      awvalid_q   <= 1'b0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      wlast_q     <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      dataok_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= {offset_width{1'b0}};
          if (addr_ok_w_s) begin
            awaddr_q    <= addr_l2cache_mem_w;
            awlen_q     <= l2cache_mem_SUC ? 8'h0 : LINE_LEN;
            awsize_q    <= l2cache_mem_SUC ? {1'b0, l2cache_mem_size} : 3'd2;
            awburst_q   <= 2'b01;
            awvalid_q   <= 1'b1;
            buf_q       <= dout_l2cache_mem;
            beat_strb_q <= l2cache_mem_SUC ? l2cache_mem_wstrb : 4'hF;
            state_q     <= WR_AW;
          end else if (addr_ok_r_s) begin
            araddr_q    <= addr_l2cache_mem_r;
            arlen_q     <= l2cache_mem_SUC ? 8'h0 : LINE_LEN;
            arsize_q    <= l2cache_mem_SUC ? {1'b0, l2cache_mem_size} : 3'd2;
            arburst_q   <= 2'b01;
            arvalid_q   <= 1'b1;
            // Cleared so an uncached read returns zeros outside word 0.
            buf_q       <= {LINE{1'b0}};
            state_q     <= RD_AR;
          end else begin
            state_q     <= IDLE;
          end
        end
        RD_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (rvalid) begin
            buf_q[{cnt_q, 5'd0} +: 32] <= rdata;
            cnt_q <= cnt_d;
            // rlast alone closes the burst; the counter simply wraps if it runs long.
            if (rlast) begin
              rready_q <= 1'b0;
              dataok_q <= 1'b1;
              state_q  <= RESP;
            end
          end
        end
        WR_AW: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= buf_q[31:0];
            wstrb_q   <= beat_strb_q;
            wlast_q   <= (awlen_q[offset_width-1:0] == {offset_width{1'b0}});
            cnt_q     <= {offset_width{1'b0}};
            state_q   <= WR_W;
          end
        end
        WR_W: begin
          if (wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= WR_B;
            end else begin
              cnt_q    <= cnt_d;
              wdata_q  <= next_word_s;
              wlast_q  <= next_last_s;
            end
          end
        end
        WR_B: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            dataok_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (l2cache_mem_rdy) begin
            dataok_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_l2cache_addrOK_w = addr_ok_w_s;
  assign mem_l2cache_addrOK_r = addr_ok_r_s;
  assign mem_l2cache_dataOK   = dataok_q;
  assign din_mem_l2cache      = buf_q;
  assign araddr               = araddr_q;
  assign arlen                = arlen_q;
  assign arsize               = arsize_q;
  assign arburst              = arburst_q;
  assign arvalid              = arvalid_q;
  assign rready               = rready_q;
  assign awaddr               = awaddr_q;
  assign awlen                = awlen_q;
  assign awsize               = awsize_q;
  assign awburst              = awburst_q;
  assign awvalid              = awvalid_q;
  assign wdata                = wdata_q;
  assign wstrb                = wstrb_q;
  assign wlast                = wlast_q;
  assign wvalid               = wvalid_q;
  assign bready               = bready_q;

endmodule
